// File: rtl/axis_rr_sel.sv
// ---------------------------------------------------------------------------
// axis_rr_sel -- round-robin packet arbiter for a merged AXI-Stream.
//
// Picks one of NUM_CH packet FIFOs and drives the select lines of a
// downstream demux. The grant is held for a whole packet and released on
// the handshaken tlast beat. Every packet is followed by one mandatory IDLE
// cycle.
//
// Ports:
//   clk            single clock, rising edge
//   rst_n          synchronous active-low reset
//   fifo_req       bit n high: FIFO n holds at least one complete packet
//   axis_in_tvalid tvalid of the merged stream toward the sink
//   axis_in_tready tready of the merged stream from the sink
//   axis_in_tlast  tlast of the merged stream
//   bus_sel        demux select: 128+n selects FIFO n, 0 selects none
//   grant          one-hot copy of the selection (all zero when none)
//   pkt_cnt        count of completed packets (wraps at 16 bits)
//   wdog_abort     one-cycle pulse when the watchdog releases a grant
//
// Build option:
//   ARB_WATCHDOG_EN  when defined, a grant that sees WDOG_CYCLES-1
//                    consecutive cycles without a tvalid&tready beat is
//                    released and wdog_abort pulses. When undefined,
//                    there is no counter and a grant is held indefinitely.
// ---------------------------------------------------------------------------
module axis_rr_sel #(
    parameter int NUM_CH      = 14,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] fifo_req,
    input  logic              axis_in_tvalid,
    input  logic              axis_in_tready,
    input  logic              axis_in_tlast,
    output logic [7:0]        bus_sel,
    output logic [NUM_CH-1:0] grant,
    output logic [15:0]       pkt_cnt,
    output logic              wdog_abort
);

    localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [6:0]          last_ptr;
    logic [6:0]          pick;
    logic                pick_vld;
    logic [7:0]          idx;
    logic [NUM_CH-1:0]   req_sh;
    logic                beat;
    logic                last_beat;
    logic                wd_fire;

    assign beat      = axis_in_tvalid & axis_in_tready;
    assign last_beat = (state == GRANT) & beat & axis_in_tlast;

    // Round-robin search: walk channels last_ptr+1, last_ptr+2, ... modulo
    // NUM_CH and keep the first requester. last_ptr itself is visited last,
    // so a sole requester is regranted.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        req_sh   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = {1'b0, last_ptr} + 8'(i);
            if (idx >= 8'(NUM_CH)) begin
                idx = idx - 8'(NUM_CH);
            end
            req_sh = fifo_req >> idx;
            if (!pick_vld && req_sh[0]) begin
                pick     = idx[6:0];
                pick_vld = 1'b1;
            end
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES) + 1;

    logic [WW-1:0] wd_cnt;

    // wd_cnt holds the number of beatless GRANT cycles seen so far; the
    // release fires in the cycle that would bring it to WDOG_CYCLES-1.
    assign wd_fire = (state == GRANT) && !beat &&
                     ((wd_cnt + WW'(1)) == WW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt     <= '0;
            wdog_abort <= 1'b0;
        end else begin
            wdog_abort <= wd_fire;
            if ((state != GRANT) || beat) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WW'(1);
            end
        end
    end
`else
    assign wd_fire    = 1'b0;
    assign wdog_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (last_beat || wd_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered select outputs: updated on entry to GRANT and on release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_sel  <= 8'd0;
            grant    <= '0;
            pkt_cnt  <= 16'd0;
            last_ptr <= 7'(NUM_CH - 1);
        end else if (state == IDLE) begin
            if (pick_vld) begin
                bus_sel  <= 8'h80 | {1'b0, pick};
                grant    <= ONE_HOT0 << pick;
                last_ptr <= pick;
            end else begin
                bus_sel <= 8'd0;
                grant   <= '0;
            end
        end else if (last_beat) begin
            bus_sel <= 8'd0;
            grant   <= '0;
            pkt_cnt <= pkt_cnt + 16'd1;
        end else if (wd_fire) begin
            bus_sel <= 8'd0;
            grant   <= '0;
        end
    end

endmodule

// File: tb/tb_axis_rr_sel.sv
module tb_axis_rr_sel;

    localparam int NC = 14;
    localparam int WD = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NC-1:0] fifo_req;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [7:0]    bus_sel;
    logic [NC-1:0] grant;
    logic [15:0]   pkt_cnt;
    logic          wdog_abort;

    always #5 clk = ~clk;

    axis_rr_sel #(.NUM_CH(NC), .WDOG_CYCLES(WD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_req      (fifo_req),
        .axis_in_tvalid(tvalid),
        .axis_in_tready(tready),
        .axis_in_tlast (tlast),
        .bus_sel       (bus_sel),
        .grant         (grant),
        .pkt_cnt       (pkt_cnt),
        .wdog_abort    (wdog_abort)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [NC-1:0] r, input logic v, input logic rd, input logic l);
        fifo_req = r;
        tvalid   = v;
        tready   = rd;
        tlast    = l;
    endtask

    // Reference model: the granted channel (-1 for none), the last winner,
    // the packet count and the beatless-cycle count.
    int          m_g;
    int          m_last;
    int unsigned m_cnt;
    int          m_wd;
    bit          m_abort;

    task automatic model_reset();
        m_g     = -1;
        m_last  = NC - 1;
        m_cnt   = 0;
        m_wd    = 0;
        m_abort = 0;
    endtask

    task automatic model_step(input logic [NC-1:0] r, input logic v, input logic rd, input logic l);
        logic [NC-1:0] sh;
        bit            found;
        int            c;
        m_abort = 0;
        if (m_g < 0) begin
            found = 0;
            for (int k = 1; k <= NC; k++) begin
                c  = (m_last + k) % NC;
                sh = r >> c;
                if (!found && sh[0]) begin
                    found  = 1;
                    m_g    = c;
                    m_last = c;
                    m_wd   = 0;
                end
            end
        end else if (v && rd) begin
            m_wd = 0;
            if (l) begin
                m_g   = -1;
                m_cnt = (m_cnt + 1) % 65536;
            end
        end else begin
`ifdef ARB_WATCHDOG_EN
            m_wd++;
            if (m_wd == WD - 1) begin
                m_g     = -1;
                m_abort = 1;
            end
`endif
        end
    endtask

    function automatic logic [31:0] m_bus();
        return (m_g < 0) ? 32'd0 : 32'(128 + m_g);
    endfunction

    function automatic logic [31:0] m_gnt();
        return (m_g < 0) ? 32'd0 : (32'd1 << m_g);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        apply('0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [NC-1:0] req;
        logic          tv;
        logic          tr;
        logic          tl;
        logic [7:0]    bus;
        logic [NC-1:0] gnt;
        logic [15:0]   cnt;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic [NC-1:0] r;
        logic          v, rd, l;

        tbl[0]  = '{14'h0001, 1'b0, 1'b0, 1'b0, 8'd128, 14'h0001, 16'd0};
        tbl[1]  = '{14'h0000, 1'b1, 1'b1, 1'b0, 8'd128, 14'h0001, 16'd0};
        tbl[2]  = '{14'h0000, 1'b1, 1'b0, 1'b1, 8'd128, 14'h0001, 16'd0};
        tbl[3]  = '{14'h0000, 1'b1, 1'b0, 1'b1, 8'd128, 14'h0001, 16'd0};
        tbl[4]  = '{14'h0000, 1'b1, 1'b0, 1'b1, 8'd128, 14'h0001, 16'd0};
        tbl[5]  = '{14'h0000, 1'b1, 1'b1, 1'b1, 8'd0,   14'h0000, 16'd1};
        tbl[6]  = '{14'h0028, 1'b0, 1'b0, 1'b0, 8'd131, 14'h0008, 16'd1};
        tbl[7]  = '{14'h0028, 1'b0, 1'b1, 1'b1, 8'd131, 14'h0008, 16'd1};
        tbl[8]  = '{14'h0028, 1'b1, 1'b1, 1'b1, 8'd0,   14'h0000, 16'd2};
        tbl[9]  = '{14'h0028, 1'b0, 1'b0, 1'b0, 8'd133, 14'h0020, 16'd2};
        tbl[10] = '{14'h0028, 1'b1, 1'b1, 1'b0, 8'd133, 14'h0020, 16'd2};
        tbl[11] = '{14'h0008, 1'b1, 1'b1, 1'b0, 8'd133, 14'h0020, 16'd2};
        tbl[12] = '{14'h0000, 1'b1, 1'b1, 1'b0, 8'd133, 14'h0020, 16'd2};
        tbl[13] = '{14'h0000, 1'b1, 1'b1, 1'b1, 8'd0,   14'h0000, 16'd3};
        tbl[14] = '{14'h2001, 1'b0, 1'b0, 1'b0, 8'd141, 14'h2000, 16'd3};
        tbl[15] = '{14'h2001, 1'b1, 1'b1, 1'b1, 8'd0,   14'h0000, 16'd4};
        tbl[16] = '{14'h2001, 1'b0, 1'b0, 1'b0, 8'd128, 14'h0001, 16'd4};
        tbl[17] = '{14'h2001, 1'b1, 1'b1, 1'b1, 8'd0,   14'h0000, 16'd5};
        tbl[18] = '{14'h0000, 1'b0, 1'b0, 1'b0, 8'd0,   14'h0000, 16'd5};

        // Reset state
        rst_n = 1'b0;
        apply(14'h0001, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_bus_sel", 32'(bus_sel), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check("rst_wdog_abort", 32'(wdog_abort), 32'd0);
        rst_n = 1'b1;

        // Table: first grant, stalled tlast, RR order, dropped request, wrap
        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].req, tbl[i].tv, tbl[i].tr, tbl[i].tl);
            tick();
            check($sformatf("tbl%0d_bus_sel", i), 32'(bus_sel), 32'(tbl[i].bus));
            check($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].gnt));
            check($sformatf("tbl%0d_pkt_cnt", i), 32'(pkt_cnt), 32'(tbl[i].cnt));
        end

        // All channels requesting, single-beat packets
        do_reset();
        apply(14'h3FFF, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 30; k++) begin
            tick();
            check($sformatf("all_req_bus_sel%0d", k), 32'(bus_sel),
                  (k % 2 == 0) ? 32'(128 + (k / 2) % NC) : 32'd0);
        end
        check("all_req_pkt_cnt", 32'(pkt_cnt), 32'd15);

        // Reset in the middle of a packet on channel 7
        do_reset();
        apply(14'h0080, 1'b0, 1'b0, 1'b0);
        tick();
        check("ch7_grant_bus_sel", 32'(bus_sel), 32'd135);
        apply(14'h0080, 1'b1, 1'b1, 1'b1);
        tick();
        check("ch7_first_pkt_cnt", 32'(pkt_cnt), 32'd1);
        apply(14'h0080, 1'b0, 1'b0, 1'b0);
        tick();
        check("ch7_regrant_bus_sel", 32'(bus_sel), 32'd135);
        apply(14'h0080, 1'b1, 1'b1, 1'b0);
        tick();
        rst_n = 1'b0;
        apply(14'h00A4, 1'b1, 1'b1, 1'b0);
        tick();
        check("midrst_bus_sel", 32'(bus_sel), 32'd0);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        rst_n = 1'b1;
        apply(14'h00A4, 1'b0, 1'b0, 1'b0);
        tick();
        check("postrst_bus_sel", 32'(bus_sel), 32'd130);

        // Grant with no beats at all
        do_reset();
        apply(14'h0011, 1'b0, 1'b0, 1'b0);
        tick();
        check("stall_grant_bus_sel", 32'(bus_sel), 32'd128);
        apply(14'h0011, 1'b0, 1'b1, 1'b0);
`ifdef ARB_WATCHDOG_EN
        for (int k = 1; k <= 14; k++) begin
            tick();
            check($sformatf("wd_hold%0d_abort", k), 32'(wdog_abort), 32'd0);
        end
        check("wd_hold_bus_sel", 32'(bus_sel), 32'd128);
        tick();
        check("wd_fire_abort", 32'(wdog_abort), 32'd1);
        check("wd_fire_bus_sel", 32'(bus_sel), 32'd0);
        check("wd_fire_pkt_cnt", 32'(pkt_cnt), 32'd0);
        tick();
        check("wd_next_abort", 32'(wdog_abort), 32'd0);
        check("wd_next_bus_sel", 32'(bus_sel), 32'd132);
`else
        for (int k = 0; k < 40; k++) begin
            tick();
        end
        check("nowd_hold_bus_sel", 32'(bus_sel), 32'd128);
        check("nowd_hold_abort", 32'(wdog_abort), 32'd0);
`endif

        // Randomised traffic against the reference model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            r  = (k % 7 == 0) ? '0 : NC'($urandom & $urandom);
            v  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) != 0);
            l  = ($urandom_range(0, 2) == 0);
            model_step(r, v, rd, l);
            apply(r, v, rd, l);
            tick();
            check($sformatf("rnd%0d_bus_sel", k), 32'(bus_sel), m_bus());
            check($sformatf("rnd%0d_grant", k), 32'(grant), m_gnt());
            check($sformatf("rnd%0d_pkt_cnt", k), 32'(pkt_cnt), 32'(m_cnt));
            check($sformatf("rnd%0d_wdog_abort", k), 32'(wdog_abort), 32'(m_abort));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_rr_sel.md
AXIS_RR_SEL -- requirements
Module: axis_rr_sel

Interface
REQ-001 SHALL have parameter NUM_CH, default 14, meaning number of FIFO channels arbitrated (1..127).
REQ-002 SHALL have parameter WDOG_CYCLES, default 1024, meaning the idle-beat limit before a grant is aborted (watchdog builds only).
REQ-003 SHALL have port clk, input, width 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, width 1, meaning the synchronous active-low reset.
REQ-005 SHALL have port fifo_req, input, width NUM_CH; bit n high means FIFO n holds at least one complete packet.
REQ-006 SHALL have port axis_in_tvalid, input, width 1, meaning tvalid of the merged stream toward the sink.
REQ-007 SHALL have port axis_in_tready, input, width 1, meaning tready of the merged stream from the sink.
REQ-008 SHALL have port axis_in_tlast, input, width 1, meaning tlast of the merged stream.
REQ-009 SHALL have port bus_sel, output, width 8, meaning channel select for the downstream demux; 128+n selects FIFO n and 0 selects none.
REQ-010 SHALL have port grant, output, width NUM_CH, meaning a one-hot copy of the current selection (all zero when none).
REQ-011 SHALL have port pkt_cnt, output, width 16, meaning the count of completed packets.
REQ-012 SHALL have port wdog_abort, output, width 1, meaning a one-cycle pulse on a watchdog release.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-014 In IDLE with fifo_req nonzero, SHALL select the first requesting channel after last_ptr in ascending modulo-NUM_CH order.
- On that selection it SHALL register bus_sel=128+n, grant[n]=1, last_ptr=n, and enter GRANT.
- bus_sel becomes valid exactly 1 cycle after the request is sampled.
REQ-015 In IDLE with fifo_req all zero, SHALL hold bus_sel=0 and grant=0.
REQ-016 In GRANT, SHALL hold bus_sel and grant constant until a beat with axis_in_tvalid & axis_in_tready & axis_in_tlast.
REQ-017 On that last beat, SHALL register bus_sel=0 and grant=0, increment pkt_cnt, and enter IDLE; the one-cycle gap between packets is mandatory.
REQ-018 SHALL ignore fifo_req changes during GRANT, including deassertion of the granted bit.
REQ-019 SHALL ignore beats without tlast for FSM purposes, and ignore tlast while tvalid or tready is low.
REQ-020 pkt_cnt SHALL wrap from 65535 to 0 without saturation or flag.
REQ-021 A sole requester SHALL be regranted after the one IDLE cycle, with no starvation of others: any requesting channel is granted within NUM_CH packets.
REQ-022 SHALL only ever produce bus_sel values in {0, 128..128+NUM_CH-1}.

Reset
REQ-023 On rst_n low at a clock edge, SHALL set: FSM=IDLE, bus_sel=0, grant=0, pkt_cnt=0, wdog_abort=0, last_ptr=NUM_CH-1 (so channel 0 wins first).
REQ-024 Reset mid-packet SHALL drop the grant with no pkt_cnt increment; recovery of the partial packet is not this block's duty.

Configuration
REQ-025 With macro ARB_WATCHDOG_EN defined, SHALL count consecutive GRANT cycles without a tvalid&tready beat.
- The counter clears on every beat.
- On reaching WDOG_CYCLES-1, the block SHALL return to IDLE, set bus_sel=0, pulse wdog_abort for 1 cycle, and leave pkt_cnt unchanged.
REQ-026 Without ARB_WATCHDOG_EN, SHALL contain no counter, tie wdog_abort to 0, and hold GRANT indefinitely.

Verification
REQ-027 Reset release, fifo_req=14'h0001 -> bus_sel=0 at cycle 0, 8'd128 at cycle 1, grant=14'h0001.
REQ-028 fifo_req=14'h3FFF held, every packet 1 beat with tlast -> bus_sel sequence 128,0,129,0,...,141,0,128; pkt_cnt=15 after 15 packets.
REQ-029 Granted ch 5, 4-beat packet, fifo_req[5] dropped after beat 1 -> bus_sel stays 133 until beat 4 handshake, then 0.
REQ-030 Granted ch 3, tlast with tready=0 for 3 cycles, then tready=1 -> release only after the tready=1 cycle; pkt_cnt +1 exactly once.
REQ-031 ARB_WATCHDOG_EN, WDOG_CYCLES=16, granted with tvalid=0 -> wdog_abort pulses after 15 beatless cycles, bus_sel=0, next requester granted in the following cycle.
REQ-032 rst_n low for 1 cycle mid-packet on ch 7 -> bus_sel=0 next cycle, pkt_cnt=0, next grant goes to lowest requesting channel.
